// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, taken-branch flush and MX/WX bypass control for the
// five-stage RV32I pipeline, with saturating stall/flush counters.
module pipeline_hazard_unit #(
    parameter int          DATAW     = 32,
    parameter int          ADDRW     = $clog2(DATAW),
    parameter int unsigned BYPASS_EN = 1,
    parameter int          CNTW      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       opcode_fd,
    input  logic [ADDRW-1:0] addr_rs1_fd,
    input  logic [ADDRW-1:0] addr_rs2_fd,
    input  logic [ADDRW-1:0] addr_rd_fd,
    input  logic             pc_sel,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             bubble_dx,
    output logic [1:0]       a_fwd_sel,
    output logic [1:0]       b_fwd_sel,
    output logic [CNTW-1:0]  stall_count,
    output logic [CNTW-1:0]  flush_count
);

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WX  = 2'b10;
    localparam logic [1:0] SEL_MX  = 2'b11;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    typedef struct packed {
        logic [ADDRW-1:0] rs1;
        logic [ADDRW-1:0] rs2;
        logic             uses_rs1;
        logic             uses_rs2;
        logic [ADDRW-1:0] rd;
        logic             writes_reg;
        logic             is_load;
    } dx_t;

    // Later stages only need what forwarding and the stall checks read.
    typedef struct packed {
        logic [ADDRW-1:0] rd;
        logic             writes_reg;
    } wb_t;

    dx_t             dx_q, dx_d, fd;
    wb_t             xm_q, xm_d, mw_q, mw_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    logic haz, haz_byp, haz_nob, bubble;
    logic a_mx, a_wx, b_mx, b_wx;

    function automatic logic hit_any(input logic [ADDRW-1:0] a,
                                     input dx_t dx,
                                     input wb_t xm,
                                     input wb_t mw);
        return (dx.writes_reg && a == dx.rd) ||
               (xm.writes_reg && a == xm.rd) ||
               (mw.writes_reg && a == mw.rd);
    endfunction

    always_comb begin
        fd            = '0;
        fd.rs1        = addr_rs1_fd;
        fd.rs2        = addr_rs2_fd;
        fd.rd         = addr_rd_fd;
        fd.writes_reg = !(opcode_fd == OP_STORE || opcode_fd == OP_BRANCH ||
                          opcode_fd == OP_SYSTEM || opcode_fd == OP_NOP) &&
                        (addr_rd_fd != '0);
        fd.uses_rs1   = !(opcode_fd == OP_LUI || opcode_fd == OP_AUIPC ||
                          opcode_fd == OP_JAL || opcode_fd == OP_NOP);
        fd.uses_rs2   = (opcode_fd == OP_REG || opcode_fd == OP_STORE ||
                         opcode_fd == OP_BRANCH);
        fd.is_load    = (opcode_fd == OP_LOAD);
    end

    always_comb begin
        haz_byp = dx_q.is_load && dx_q.writes_reg &&
                  ((fd.uses_rs1 && fd.rs1 == dx_q.rd) ||
                   (fd.uses_rs2 && fd.rs2 == dx_q.rd));
        // Without write-through the consumer waits until the producer leaves MW.
        haz_nob = (fd.uses_rs1 && hit_any(fd.rs1, dx_q, xm_q, mw_q)) ||
                  (fd.uses_rs2 && hit_any(fd.rs2, dx_q, xm_q, mw_q));
        haz     = (BYPASS_EN != 0) ? haz_byp : haz_nob;
        bubble  = pc_sel || haz;
    end

    always_comb begin
        a_mx = dx_q.uses_rs1 && xm_q.writes_reg && dx_q.rs1 == xm_q.rd;
        a_wx = dx_q.uses_rs1 && mw_q.writes_reg && dx_q.rs1 == mw_q.rd;
        b_mx = dx_q.uses_rs2 && xm_q.writes_reg && dx_q.rs2 == xm_q.rd;
        b_wx = dx_q.uses_rs2 && mw_q.writes_reg && dx_q.rs2 == mw_q.rd;
    end

    always_comb begin
        stall_pc  = !reset && !pc_sel && haz;
        stall_fd  = !reset && !pc_sel && haz;
        flush_fd  = !reset && pc_sel;
        bubble_dx = !reset && bubble;
        a_fwd_sel = SEL_REG;
        b_fwd_sel = SEL_REG;
        if (!reset && BYPASS_EN != 0) begin
            a_fwd_sel = a_mx ? SEL_MX : (a_wx ? SEL_WX : SEL_REG);
            b_fwd_sel = b_mx ? SEL_MX : (b_wx ? SEL_WX : SEL_REG);
        end
    end

    always_comb begin
        dx_d        = bubble ? '0 : fd;
        xm_d.rd         = dx_q.rd;
        xm_d.writes_reg = dx_q.writes_reg;
        mw_d        = xm_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (haz && !pc_sel && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (pc_sel && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dx_q        <= '0;
            xm_q        <= '0;
            mw_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            dx_q        <= dx_d;
            xm_q        <= xm_d;
            mw_q        <= mw_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: three configurations (bypass, no-bypass, 2-bit counters)
// share one decode stream; each phase checks only its own instance.
module tb_pipeline_hazard_unit;

    localparam logic [6:0] NOP = 7'b0000000;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] RI  = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] JAL = 7'b1101111;

    // {stall_pc, stall_fd, flush_fd, bubble_dx}
    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] STALL = 4'b1101;
    localparam logic [3:0] FLUSH = 4'b0011;

    typedef struct {
        int         dut;
        string      nm;
        logic [3:0] ctl;
        bit         cs;
        logic [1:0] a;
        logic [1:0] b;
        bit         cc;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode_fd;
    logic [4:0] addr_rs1_fd, addr_rs2_fd, addr_rd_fd;
    logic       pc_sel;

    logic        spc0, sfd0, ffd0, bdx0;
    logic        spc1, sfd1, ffd1, bdx1;
    logic        spc2, sfd2, ffd2, bdx2;
    logic [1:0]  a0, b0, a1, b1, a2, b2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    logic [3:0] ctl_o[3];
    logic [1:0] a_o[3];
    logic [1:0] b_o[3];
    int         sc_o[3];
    int         fc_o[3];

    always #5 clock = ~clock;

    pipeline_hazard_unit #(.BYPASS_EN(1), .CNTW(16)) u_byp (
        .clock(clock), .reset(reset), .opcode_fd(opcode_fd),
        .addr_rs1_fd(addr_rs1_fd), .addr_rs2_fd(addr_rs2_fd),
        .addr_rd_fd(addr_rd_fd), .pc_sel(pc_sel),
        .stall_pc(spc0), .stall_fd(sfd0), .flush_fd(ffd0),
        .bubble_dx(bdx0), .a_fwd_sel(a0), .b_fwd_sel(b0),
        .stall_count(sc0), .flush_count(fc0)
    );

    pipeline_hazard_unit #(.BYPASS_EN(0), .CNTW(16)) u_nob (
        .clock(clock), .reset(reset), .opcode_fd(opcode_fd),
        .addr_rs1_fd(addr_rs1_fd), .addr_rs2_fd(addr_rs2_fd),
        .addr_rd_fd(addr_rd_fd), .pc_sel(pc_sel),
        .stall_pc(spc1), .stall_fd(sfd1), .flush_fd(ffd1),
        .bubble_dx(bdx1), .a_fwd_sel(a1), .b_fwd_sel(b1),
        .stall_count(sc1), .flush_count(fc1)
    );

    pipeline_hazard_unit #(.BYPASS_EN(0), .CNTW(2)) u_sat (
        .clock(clock), .reset(reset), .opcode_fd(opcode_fd),
        .addr_rs1_fd(addr_rs1_fd), .addr_rs2_fd(addr_rs2_fd),
        .addr_rd_fd(addr_rd_fd), .pc_sel(pc_sel),
        .stall_pc(spc2), .stall_fd(sfd2), .flush_fd(ffd2),
        .bubble_dx(bdx2), .a_fwd_sel(a2), .b_fwd_sel(b2),
        .stall_count(sc2), .flush_count(fc2)
    );

    always_comb begin
        ctl_o[0] = {spc0, sfd0, ffd0, bdx0};
        ctl_o[1] = {spc1, sfd1, ffd1, bdx1};
        ctl_o[2] = {spc2, sfd2, ffd2, bdx2};
        a_o[0] = a0; a_o[1] = a1; a_o[2] = a2;
        b_o[0] = b0; b_o[1] = b1; b_o[2] = b2;
        sc_o[0] = int'(sc0); sc_o[1] = int'(sc1); sc_o[2] = int'(sc2);
        fc_o[0] = int'(fc0); fc_o[1] = int'(fc1); fc_o[2] = int'(fc2);
    end

    task automatic step(input int dut, input string nm, input logic rst,
                        input logic [6:0] op, input int s1, input int s2,
                        input int d, input logic ps, input logic [3:0] ctl,
                        input bit cs, input logic [1:0] ea,
                        input logic [1:0] eb, input bit cc,
                        input int sc, input int fc);
        exp_t e;
        @(posedge clock);
        #1;
        reset       = rst;
        opcode_fd   = op;
        addr_rs1_fd = 5'(s1);
        addr_rs2_fd = 5'(s2);
        addr_rd_fd  = 5'(d);
        pc_sel      = ps;
        e.dut = dut; e.nm = nm; e.ctl = ctl;
        e.cs = cs; e.a = ea; e.b = eb;
        e.cc = cc; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    exp_t m;
    always @(negedge clock) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            total++;
            if (ctl_o[m.dut] !== m.ctl) begin
                bad++;
                $display("FAIL %s ctl: got %b want %b",
                         m.nm, ctl_o[m.dut], m.ctl);
            end
            if (m.cs) begin
                total++;
                if (a_o[m.dut] !== m.a || b_o[m.dut] !== m.b) begin
                    bad++;
                    $display("FAIL %s sel: got a=%b b=%b want a=%b b=%b",
                             m.nm, a_o[m.dut], b_o[m.dut], m.a, m.b);
                end
            end
            if (m.cc) begin
                total++;
                if (sc_o[m.dut] != m.sc || fc_o[m.dut] != m.fc) begin
                    bad++;
                    $display("FAIL %s cnt: got s=%0d f=%0d want s=%0d f=%0d",
                             m.nm, sc_o[m.dut], fc_o[m.dut], m.sc, m.fc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; opcode_fd = NOP; pc_sel = 1'b0;
        addr_rs1_fd = '0; addr_rs2_fd = '0; addr_rd_fd = '0;

        // bypass configuration
        step(0, "rst", 1, RR, 5, 5, 6, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "rst2", 1, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "prod", 0, RR, 1, 2, 5, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "alu_nohaz", 0, RR, 5, 5, 6, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "mx_ab", 0, RI, 1, 6, 10, 0, NONE, 1, 2'b11, 2'b11, 1, 0, 0);
        step(0, "rs2_gate", 0, RR, 5, 6, 11, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "wx_b", 0, RR, 11, 10, 12, 0, NONE, 1, 2'b00, 2'b10, 0, 0, 0);
        step(0, "mx_wx", 0, RR, 1, 2, 13, 0, NONE, 1, 2'b11, 2'b10, 0, 0, 0);
        step(0, "p13a", 0, RR, 1, 2, 13, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "p13b", 0, RR, 13, 0, 14, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "mx_prio", 0, NOP, 0, 0, 0, 0, NONE, 1, 2'b11, 2'b00, 0, 0, 0);
        step(0, "lw7", 0, LD, 1, 0, 7, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "lu_stall", 0, RR, 7, 1, 8, 0, STALL, 1, 2'b00, 2'b00, 1, 0, 0);
        step(0, "lu_rel", 0, RR, 7, 1, 8, 0, NONE, 1, 2'b00, 2'b00, 1, 1, 0);
        step(0, "lw9", 0, LD, 2, 0, 9, 0, NONE, 0, 2'b00, 2'b00, 1, 1, 0);
        step(0, "lu_rs2", 0, ST, 2, 9, 0, 0, STALL, 1, 2'b00, 2'b00, 1, 1, 0);
        step(0, "lu_rs2_rel", 0, ST, 2, 9, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 2, 0);
        step(0, "wx_ld", 0, LD, 1, 0, 7, 0, NONE, 1, 2'b00, 2'b10, 1, 2, 0);
        step(0, "flush", 0, RR, 7, 1, 8, 1, FLUSH, 1, 2'b00, 2'b00, 1, 2, 0);
        step(0, "flush_cnt", 0, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 2, 1);
        step(0, "lw0", 0, LD, 1, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "x0_nohaz", 0, RR, 0, 0, 8, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "x0_nofwd", 0, LD, 1, 0, 7, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "lui_nohaz", 0, LUI, 7, 7, 7, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "lw7b", 0, LD, 1, 0, 7, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, "jal_nohaz", 0, JAL, 7, 7, 1, 0, NONE, 1, 2'b00, 2'b00, 1, 2, 1);
        step(0, "flush2", 0, NOP, 0, 0, 0, 1, FLUSH, 0, 2'b00, 2'b00, 1, 2, 1);
        step(0, "flush2_cnt", 0, NOP, 0, 0, 0, 0, NONE, 0, 2'b00, 2'b00, 1, 2, 2);

        // no-bypass configuration
        step(1, "nb_rst", 1, RR, 1, 1, 1, 1, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(1, "nb_rst2", 1, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(1, "nb_prod", 0, RI, 1, 0, 3, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(1, "nb_s1", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 0, 0);
        step(1, "nb_s2", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 1, 0);
        step(1, "nb_s3", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 2, 0);
        step(1, "nb_rel", 0, RR, 3, 2, 4, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_sel0", 0, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_w0", 0, RI, 1, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_x0", 0, RR, 0, 0, 8, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_p5", 0, RI, 1, 0, 5, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_n1", 0, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_n2", 0, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_mw", 0, RR, 5, 0, 6, 0, STALL, 1, 2'b00, 2'b00, 1, 3, 0);
        step(1, "nb_mw_rel", 0, RR, 5, 0, 6, 0, NONE, 1, 2'b00, 2'b00, 1, 4, 0);

        // 2-bit counter saturation and reset mid-stall
        step(2, "sat_rst", 1, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 0, 0, 0);
        step(2, "sat_rst2", 1, NOP, 0, 0, 0, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(2, "sat_p", 0, RI, 1, 0, 3, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);
        step(2, "sat_s1", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 0, 0);
        step(2, "sat_s2", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 1, 0);
        step(2, "sat_s3", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 2, 0);
        step(2, "sat_rel", 0, RR, 3, 2, 4, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(2, "sat_p2", 0, RI, 1, 0, 3, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(2, "sat_s4", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 3, 0);
        step(2, "sat_s5", 0, RR, 3, 2, 4, 0, STALL, 1, 2'b00, 2'b00, 1, 3, 0);
        step(2, "rst_mid", 1, RR, 3, 2, 4, 0, NONE, 1, 2'b00, 2'b00, 1, 3, 0);
        step(2, "rst_clr", 0, RR, 3, 2, 4, 0, NONE, 1, 2'b00, 2'b00, 1, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
